// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Two-read / one-write register file with a busy-bit scoreboard for long-latency
// writebacks and a one-deep shadow bank for context save/restore.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a same-cycle write is forwarded combinationally to rd_a_data,
//               rd_b_data and tap_data when the addresses match. The write also
//               masks the matching busy bit in the stall equation. Forwarding is
//               suppressed by a valid restore in the same cycle.
//   undefined : reads and stall see only the pre-edge register and busy state.
//
// Ports
//   clk, reset               clock (rising edge), asynchronous active-high reset
//   rd_a_addr / rd_a_data    read port A (combinational)
//   rd_b_addr / rd_b_data    read port B (combinational)
//   tap_data                 contents of register TAP_REG (combinational)
//   wr_en/wr_addr/wr_data    write port; a write clears the busy bit of its register
//   busy_set/busy_addr       mark a register as pending a long-latency writeback
//   rd_a_used / rd_b_used    the read on that port is consumed this cycle
//   stall                    a consumed read targets a busy register
//   snap_save                copy the live registers into the shadow bank
//   snap_restore             copy the shadow bank back (only when snap_valid)
//   snap_valid               the shadow bank holds a saved context

module regfile_scoreboard #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAP_REG = 1,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rd_a_addr,
    input  logic [AW-1:0]    rd_b_addr,
    output logic [WIDTH-1:0] rd_a_data,
    output logic [WIDTH-1:0] rd_b_data,
    output logic [WIDTH-1:0] tap_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             busy_set,
    input  logic [AW-1:0]    busy_addr,
    input  logic             rd_a_used,
    input  logic             rd_b_used,
    output logic             stall,
    input  logic             snap_save,
    input  logic             snap_restore,
    output logic             snap_valid
);

    localparam logic [AW-1:0] TAP_IDX = AW'(TAP_REG);

    logic [DEPTH-1:0][WIDTH-1:0] regs_q,   regs_d;
    logic [DEPTH-1:0][WIDTH-1:0] shadow_q, shadow_d;
    logic [DEPTH-1:0]            busy_q,   busy_d;
    logic                        valid_q,  valid_d;

    logic restore_c;
    logic fwd_en_c;
    logic hit_a_c;
    logic hit_b_c;
    logic hit_tap_c;

    // A restore only acts when a context has actually been saved.
    assign restore_c = snap_restore & valid_q;

    // Forwarding is blocked by reset so outputs read zero while reset is high,
    // and by a valid restore because the restore discards the write.
`ifdef REGFILE_BYPASS_EN
    assign fwd_en_c = wr_en & ~restore_c & ~reset;
`else
    assign fwd_en_c = 1'b0;
`endif

    assign hit_a_c   = fwd_en_c & (wr_addr == rd_a_addr);
    assign hit_b_c   = fwd_en_c & (wr_addr == rd_b_addr);
    assign hit_tap_c = fwd_en_c & (wr_addr == TAP_IDX);

    // Combinational read ports and tap.
    assign rd_a_data = hit_a_c   ? wr_data : regs_q[rd_a_addr];
    assign rd_b_data = hit_b_c   ? wr_data : regs_q[rd_b_addr];
    assign tap_data  = hit_tap_c ? wr_data : regs_q[TAP_IDX];

    // A forwarded write satisfies the pending writeback, so it masks that busy bit.
    assign stall = (rd_a_used & busy_q[rd_a_addr] & ~hit_a_c)
                 | (rd_b_used & busy_q[rd_b_addr] & ~hit_b_c);

    assign snap_valid = valid_q;

    // Next-state: restore overrides write/busy; save always samples pre-edge regs,
    // which turns save+restore into a swap of live and shadow contexts.
    always_comb begin
        regs_d   = regs_q;
        shadow_d = shadow_q;
        busy_d   = busy_q;
        valid_d  = valid_q;

        if (restore_c) begin
            regs_d  = shadow_q;
            busy_d  = '0;
            valid_d = 1'b0;
        end else begin
            if (wr_en) begin
                regs_d[wr_addr] = wr_data;
                busy_d[wr_addr] = 1'b0;
            end
            // Applied after the write so a same-address set wins.
            if (busy_set) begin
                busy_d[busy_addr] = 1'b1;
            end
        end

        if (snap_save) begin
            shadow_d = regs_q;
            valid_d  = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q   <= '0;
            shadow_q <= '0;
            busy_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard (WIDTH=8, DEPTH=4, TAP_REG=1).
// Expected outputs are pushed to a queue with each stimulus and popped when the
// DUT outputs are sampled, one millisecond-free step after the clock edge.

module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [1:0] rd_a_addr;
    logic [1:0] rd_b_addr;
    logic [7:0] rd_a_data;
    logic [7:0] rd_b_data;
    logic [7:0] tap_data;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy_set;
    logic [1:0] busy_addr;
    logic       rd_a_used;
    logic       rd_b_used;
    logic       stall;
    logic       snap_save;
    logic       snap_restore;
    logic       snap_valid;

    int errors;
    int checks;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] tap;
        logic       stall;
        logic       valid;
    } exp_t;

    exp_t exp_q[$];

    regfile_scoreboard #(
        .WIDTH   (8),
        .DEPTH   (4),
        .TAP_REG (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_a_addr    (rd_a_addr),
        .rd_b_addr    (rd_b_addr),
        .rd_a_data    (rd_a_data),
        .rd_b_data    (rd_b_data),
        .tap_data     (tap_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy_set     (busy_set),
        .busy_addr    (busy_addr),
        .rd_a_used    (rd_a_used),
        .rd_b_used    (rd_b_used),
        .stall        (stall),
        .snap_save    (snap_save),
        .snap_restore (snap_restore),
        .snap_valid   (snap_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string n, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] tap, input logic s, input logic v);
        exp_t t;
        t.name  = n;
        t.a     = a;
        t.b     = b;
        t.tap   = tap;
        t.stall = s;
        t.valid = v;
        exp_q.push_back(t);
    endtask

    task automatic set_rd(input logic [1:0] aa, input logic au, input logic [1:0] ba, input logic bu);
        rd_a_addr = aa;
        rd_a_used = au;
        rd_b_addr = ba;
        rd_b_used = bu;
    endtask

    // One clock edge; strobes are dropped after the edge so the sample sees state only.
    task automatic step();
        @(posedge clk);
        #1;
        wr_en        = 1'b0;
        busy_set     = 1'b0;
        snap_save    = 1'b0;
        snap_restore = 1'b0;
        #1;
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
    endtask

    task automatic do_busy(input logic [1:0] addr);
        busy_set  = 1'b1;
        busy_addr = addr;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        set_rd(2'd2, 1'b1, 2'd1, 1'b1);
        do_write(2'd2, 8'h5A);
        do_busy(2'd2);
        snap_save = 1'b1;
        push_exp("reset_hold", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        wr_en = 1'b0; busy_set = 1'b0; snap_save = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step();
        push_exp("reset_release", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        set_rd(2'd2, 1'b0, 2'd1, 1'b0);
        do_write(2'd2, 8'hA5);
        #1;
        push_exp("wr_pre_edge", BYP ? 8'hA5 : 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        step();
        push_exp("wr_visible", 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
    endtask

    task automatic test_busy_stall();
        exp_t e;
        do_busy(2'd3);
        set_rd(2'd3, 1'b1, 2'd0, 1'b0);
        step();
        push_exp("busy_stall", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        rd_a_used = 1'b0;
        #1;
        push_exp("busy_unused", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        rd_a_used = 1'b1;
        do_write(2'd3, 8'h3C);
        #1;
        push_exp("wb_same_cycle", BYP ? 8'h3C : 8'h00, 8'h00, 8'h00, BYP ? 1'b0 : 1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        step();
        push_exp("wb_next_cycle", 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        do_busy(2'd2);
        set_rd(2'd0, 1'b0, 2'd2, 1'b1);
        step();
        push_exp("busy_port_b", 8'h00, 8'hA5, 8'h00, 1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        do_write(2'd2, 8'hA6);
        step();
        push_exp("wb_port_b", 8'h00, 8'hA6, 8'h00, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
    endtask

    task automatic test_same_cycle();
        exp_t e;
        do_busy(2'd1);
        do_write(2'd1, 8'h11);
        set_rd(2'd1, 1'b1, 2'd0, 1'b0);
        step();
        push_exp("set_wins", 8'h11, 8'h00, 8'h11, 1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        do_busy(2'd0);
        do_write(2'd3, 8'h44);
        set_rd(2'd0, 1'b1, 2'd3, 1'b0);
        step();
        push_exp("diff_addr", 8'h00, 8'h44, 8'h11, 1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
    endtask

    task automatic test_save_restore();
        exp_t e;
        set_rd(2'd0, 1'b0, 2'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_write(2'(i), 8'(i + 1));
            step();
        end
        set_rd(2'd0, 1'b1, 2'd1, 1'b1);
        #1;
        push_exp("regs_loaded", 8'h01, 8'h02, 8'h02, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        do_busy(2'd2);
        step();
        snap_save = 1'b1;
        do_write(2'd0, 8'hFF);
        step();
        push_exp("save_same_write", 8'hFF, 8'h02, 8'h02, 1'b0, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        snap_restore = 1'b1;
        do_write(2'd3, 8'h99);
        do_busy(2'd1);
        set_rd(2'd0, 1'b1, 2'd3, 1'b1);
        step();
        push_exp("restore", 8'h01, 8'h04, 8'h02, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        set_rd(2'd2, 1'b1, 2'd1, 1'b1);
        #1;
        push_exp("restore_clr_busy", 8'h03, 8'h02, 8'h02, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
    endtask

    task automatic test_restore_invalid();
        exp_t e;
        snap_restore = 1'b1;
        do_write(2'd2, 8'h77);
        do_busy(2'd1);
        set_rd(2'd2, 1'b1, 2'd1, 1'b1);
        step();
        push_exp("restore_ignored", 8'h77, 8'h02, 8'h02, 1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        do_write(2'd1, 8'h22);
        step();
        push_exp("clear_r1", 8'h77, 8'h22, 8'h22, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
    endtask

    task automatic test_swap();
        exp_t e;
        snap_save = 1'b1;
        step();
        do_write(2'd0, 8'hAB);
        set_rd(2'd0, 1'b1, 2'd1, 1'b1);
        step();
        push_exp("pre_swap", 8'hAB, 8'h22, 8'h22, 1'b0, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        snap_save    = 1'b1;
        snap_restore = 1'b1;
        step();
        push_exp("swap", 8'h01, 8'h22, 8'h22, 1'b0, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        snap_restore = 1'b1;
        step();
        push_exp("swap_back", 8'hAB, 8'h22, 8'h22, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_busy(2'd2);
        snap_save = 1'b1;
        set_rd(2'd2, 1'b1, 2'd0, 1'b0);
        step();
        push_exp("pre_reset", 8'h77, 8'hAB, 8'h22, 1'b1, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        #2;
        reset = 1'b1;
        #1;
        push_exp("reset_async", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
        #3;
        reset = 1'b0;
        snap_restore = 1'b1;
        step();
        push_exp("post_reset_restore", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rd_a_data, rd_b_data, tap_data, stall, snap_valid} !== {e.a, e.b, e.tap, e.stall, e.valid}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h tap=%h stall=%b valid=%b, want a=%h b=%h tap=%h stall=%b valid=%b",
                     e.name, rd_a_data, rd_b_data, tap_data, stall, snap_valid, e.a, e.b, e.tap, e.stall, e.valid);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b1;
        rd_a_addr    = '0;
        rd_b_addr    = '0;
        rd_a_used    = 1'b0;
        rd_b_used    = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        busy_set     = 1'b0;
        busy_addr    = '0;
        snap_save    = 1'b0;
        snap_restore = 1'b0;

        test_reset();
        test_write_read();
        test_busy_stall();
        test_same_cycle();
        test_save_restore();
        test_restore_invalid();
        test_swap();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
